// File: rtl/conversor_bcd_pkg.sv
// Shared constants for the BCD converter: FSM encodings, double-dabble adjust values, 7-seg codes.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package conversor_bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_ADJ_TH = 4'd5;
    localparam logic [3:0] BCD_ADJ    = 4'd3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Pre-shift correction so each digit stays decimal after doubling.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
        return (d >= BCD_ADJ_TH) ? d + BCD_ADJ : d;
    endfunction

endpackage

// File: rtl/conversor_bcd_if.sv
// Request/result bundle between the arithmetic stage (master) and the BCD converter (slave).
// The hex field exists only when SEG7_EN is defined.
interface conversor_bcd_if #(
    parameter int W_IN  = 8,
    parameter int N_DIG = 3
);
    logic                 start;
    logic [W_IN-1:0]      s;
    logic                 cout;
    logic                 busy;
    logic                 done;
    logic [4*N_DIG-1:0]   bcd;
`ifdef SEG7_EN
    logic [7*N_DIG-1:0]   hex;

    modport master (output start, s, cout, input busy, done, bcd, hex);
    modport slave  (input start, s, cout, output busy, done, bcd, hex);
`else
    modport master (output start, s, cout, input busy, done, bcd);
    modport slave  (input start, s, cout, output busy, done, bcd);
`endif
endinterface

// File: rtl/conversor_bcd_dec7seg.sv
// dec7seg: one BCD digit to active-low 7-segment pattern, purely combinational.
// Latency: 0 cycles. No flow control; codes 10..15 show blank.
module dec7seg
    import conversor_bcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/conversor_bcd.sv
// conversor_bcd: {cout,s} to packed BCD via sequential double-dabble, one bit per cycle (SEG7_EN adds hex).
// Latency: done W_IN+1 cycles after the accepting edge; one result every W_IN+2 cycles.
// Backpressure: start is ignored while busy; s/cout are sampled only on the accepting edge.
module conversor_bcd
    import conversor_bcd_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int N_DIG = 3
) (
    input  logic            clk,
    input  logic            rst,
    conversor_bcd_if.slave  bus
);
    localparam int              CW   = $clog2(W_IN + 2);
    localparam logic [CW-1:0]   LAST = CW'(W_IN);

    logic [1:0]           state;
    logic [W_IN:0]        shreg;
    logic [4*N_DIG-1:0]   scratch;
    logic [4*N_DIG-1:0]   adj;
    logic [4*N_DIG-1:0]   scratch_nxt;
    logic [4*N_DIG-1:0]   bcd_q;
    logic [CW-1:0]        cnt;
    logic                 finish;

    always_comb begin
        adj = '0;
        for (int i = 0; i < N_DIG; i++) begin
            adj[4*i +: 4] = bcd_adjust(scratch[4*i +: 4]);
        end
    end

    assign scratch_nxt = (adj << 1) | (4*N_DIG)'(shreg[W_IN]);
    assign finish      = (state == ST_SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        shreg   <= {bus.cout, bus.s};
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg << 1;
                    cnt     <= cnt + 1'b1;
                    // bcd takes the post-shift value so it never exposes partial digits
                    if (finish) begin
                        bcd_q <= scratch_nxt;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.bcd  = bcd_q;

`ifdef SEG7_EN
    logic [7*N_DIG-1:0] seg_nxt;
    logic [7*N_DIG-1:0] hex_q;

    for (genvar g = 0; g < N_DIG; g++) begin : g_seg
        dec7seg u_dec (
            .bcd (scratch_nxt[4*g +: 4]),
            .seg (seg_nxt[7*g +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q <= '1;
        end else if (finish) begin
            hex_q <= seg_nxt;
        end
    end

    assign bus.hex = hex_q;
`endif

endmodule

// File: tb/tb_conversor_bcd.sv
// Randomized self-checking bench for conversor_bcd against an arithmetic decimal reference.
// Define SEG7_EN to also check the 7-segment output.
module tb_conversor_bcd;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    conversor_bcd_if #(.W_IN(8), .N_DIG(3)) bus ();

    conversor_bcd #(.W_IN(8), .N_DIG(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10];

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [20:0] ref_hex(input int v);
        return {seg_tab[v / 100], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
    endfunction

    task automatic do_start(input int v);
        @(negedge clk);
        bus.start = 1'b1;
        {bus.cout, bus.s} = 9'(v);
        @(negedge clk);
        bus.start = 1'b0;
        {bus.cout, bus.s} = 9'($urandom);
    endtask

    // lat = edges after the accepting edge until done is seen; 99 if it never comes.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) lat = 99;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        {bus.cout, bus.s} = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_checks++;
        if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=000", bus.bcd); end
`ifdef SEG7_EN
        n_checks++;
        if (bus.hex !== 21'h1FFFFF) begin n_fail++; $display("FAIL reset_hex got=%h exp=1fffff", bus.hex); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        int busy_cnt;
        do_start(11);
        busy_cnt = 0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (lat == 4) begin
                n_checks++;
                if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL basic_no_partial got=%h exp=000", bus.bcd); end
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        n_checks++;
        if (busy_cnt !== 9) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=9", busy_cnt); end
        n_checks++;
        if (bus.bcd !== 12'h011) begin n_fail++; $display("FAIL basic_bcd got=%h exp=011", bus.bcd); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy); end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        n_checks++;
        if (bus.bcd !== 12'h011) begin n_fail++; $display("FAIL basic_bcd_hold got=%h exp=011", bus.bcd); end
    endtask

    task automatic test_back_to_back;
        int lat1;
        int lat2;
        @(negedge clk);
        bus.start = 1'b1;
        {bus.cout, bus.s} = 9'd2;
        @(negedge clk);
        wait_done(lat1);
        n_checks++;
        if (bus.bcd !== 12'h002) begin n_fail++; $display("FAIL b2b_first_bcd got=%h exp=002", bus.bcd); end
        {bus.cout, bus.s} = 9'd0;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", bus.busy); end
        n_checks++;
        if (bus.bcd !== 12'h002) begin n_fail++; $display("FAIL b2b_hold_bcd got=%h exp=002", bus.bcd); end
        wait_done(lat2);
        n_checks++;
        if (lat2 + 1 !== 10) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=10", lat2 + 1); end
        n_checks++;
        if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL b2b_zero_bcd got=%h exp=000", bus.bcd); end
    endtask

    task automatic test_boundaries;
        int vals [3];
        int lat;
        vals = '{511, 255, 0};
        foreach (vals[k]) begin
            do_start(vals[k]);
            wait_done(lat);
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL bound_latency v=%0d got=%0d exp=9", vals[k], lat); end
            n_checks++;
            if (bus.bcd !== ref_bcd(vals[k])) begin
                n_fail++; $display("FAIL bound_bcd v=%0d got=%h exp=%h", vals[k], bus.bcd, ref_bcd(vals[k]));
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        do_start(123);
        bus.start = 1'b1;
        {bus.cout, bus.s} = 9'd400;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        n_checks++;
        if (lat + 3 !== 9) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=9", lat + 3); end
        n_checks++;
        if (bus.bcd !== 12'h123) begin n_fail++; $display("FAIL ignore_bcd got=%h exp=123", bus.bcd); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit saw_done;
        do_start(300);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        n_checks++;
        if (bus.bcd !== 12'h000) begin n_fail++; $display("FAIL rstmid_bcd got=%h exp=000", bus.bcd); end
`ifdef SEG7_EN
        n_checks++;
        if (bus.hex !== 21'h1FFFFF) begin n_fail++; $display("FAIL rstmid_hex got=%h exp=1fffff", bus.hex); end
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got=%b exp=0", saw_done); end
        do_start(77);
        wait_done(lat);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL rstmid_next_latency got=%0d exp=9", lat); end
        n_checks++;
        if (bus.bcd !== 12'h077) begin n_fail++; $display("FAIL rstmid_next_bcd got=%h exp=077", bus.bcd); end
    endtask

    task automatic test_random;
        int v;
        int lat;
        for (int it = 0; it < 24; it++) begin
            v = int'($urandom_range(0, 511));
            do_start(v);
            wait_done(lat);
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL rand_latency v=%0d got=%0d exp=9", v, lat); end
            n_checks++;
            if (bus.bcd !== ref_bcd(v)) begin
                n_fail++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bus.bcd, ref_bcd(v));
            end
`ifdef SEG7_EN
            n_checks++;
            if (bus.hex !== ref_hex(v)) begin
                n_fail++; $display("FAIL rand_hex v=%0d got=%h exp=%h", v, bus.hex, ref_hex(v));
            end
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

`ifdef SEG7_EN
    task automatic test_seg7;
        int lat;
        do_start(1);
        wait_done(lat);
        n_checks++;
        if (bus.hex[6:0] !== 7'b1111001) begin n_fail++; $display("FAIL seg_units got=%b exp=1111001", bus.hex[6:0]); end
        n_checks++;
        if (bus.hex[13:7] !== 7'b1000000) begin n_fail++; $display("FAIL seg_tens got=%b exp=1000000", bus.hex[13:7]); end
        n_checks++;
        if (bus.hex[20:14] !== 7'b1000000) begin n_fail++; $display("FAIL seg_hund got=%b exp=1000000", bus.hex[20:14]); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seg_tab  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundaries();
        test_ignore_start();
        test_reset_mid();
`ifdef SEG7_EN
        test_seg7();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
